allocator_writeback: RTL and testbench

Downstream stage of the allocator array; consumes each allocator's done/result_data pair. Adds the filter bias, applies leaky ReLU and writes the activation to the output feature-map memory. Frees each allocator with a one-cycle ack so the controller can reposition it. Holds one pending result per allocator slot, serviced by a round-robin arbiter and a 2-stage pipeline with output backpressure.

---
 rtl/allocator_writeback.sv | 102 ++++++++++
 tb/tb_allocator_writeback.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/allocator_writeback.sv
// allocator_writeback: round-robin drain of allocator results through bias add, saturation and optional leaky ReLU (WRITEBACK_LEAKY_RELU_EN) into output memory.
module allocator_writeback #(
  parameter int NUM_ALLOC  = 4,
  parameter int ADDR_W     = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_ALLOC-1:0]    alloc_assign,
  input  logic [ADDR_W-1:0]       assign_addr,
  input  logic [NUM_ALLOC-1:0]    alloc_done,
  input  logic [18*NUM_ALLOC-1:0] alloc_result,
  input  logic [17:0]             filter_bias,
  output logic [NUM_ALLOC-1:0]    alloc_ack,
  output logic                    mem_write_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [17:0]             mem_data,
  input  logic                    mem_ready,
  output logic                    idle,
  output logic                    overflow
);
  localparam int PW = NUM_ALLOC > 1 ? $clog2(NUM_ALLOC) : 1;
  if (NUM_ALLOC < 1 || NUM_ALLOC > 16 || LEAK_SHIFT < 1 || LEAK_SHIFT > 17) begin : g_bad_param
    $error("allocator_writeback: parameter out of range");
  end
  logic [NUM_ALLOC-1:0] pending, pend_nx, cap, grant_oh;
  logic [17:0]          res [NUM_ALLOC];
  logic [ADDR_W-1:0]    slot_addr [NUM_ALLOC];
  logic [ADDR_W-1:0]    res_addr [NUM_ALLOC];
  logic [PW-1:0]        ptr, g, idx;
  logic                 gnt_v, s1_v, s1_adv, s2_load, s1_nx, s2_nx;
  logic signed [17:0]   s1_sum, act;
  logic [ADDR_W-1:0]    s1_addr;
  logic [18:0]          sum19;
  logic [17:0]          sat;
  assign s2_load = !mem_write_en || mem_ready;
  assign s1_adv  = !s1_v || s2_load;
  // Scan downward so the slot closest to the pointer wins.
  always_comb begin
    gnt_v = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = NUM_ALLOC - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_ALLOC);
      if (pending[idx]) begin
        gnt_v = 1'b1;
        g     = idx;
      end
    end
    gnt_v = gnt_v && s1_adv && rst;
  end
  assign grant_oh  = gnt_v ? NUM_ALLOC'(1) << g : '0;
  assign cap       = alloc_done & (~pending | grant_oh);
  assign pend_nx   = cap | (pending & ~grant_oh);
  assign s1_nx     = s1_adv ? gnt_v : s1_v;
  assign s2_nx     = s2_load ? s1_v : mem_write_en;
  assign alloc_ack = grant_oh;
  assign sum19     = {res[g][17], res[g]} + {filter_bias[17], filter_bias};
  assign sat       = sum19[18] != sum19[17] ? {sum19[18], {17{~sum19[18]}}} : sum19[17:0];
`ifdef WRITEBACK_LEAKY_RELU_EN
  assign act = s1_sum[17] ? s1_sum >>> LEAK_SHIFT : s1_sum;
`else
  assign act = s1_sum;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending      <= '0;
      ptr          <= '0;
      s1_v         <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      overflow     <= 1'b0;
      idle         <= 1'b1;
      for (int i = 0; i < NUM_ALLOC; i++) slot_addr[i] <= '0;
    end else begin
      pending      <= pend_nx;
      overflow     <= overflow | |(alloc_done & pending & ~grant_oh);
      idle         <= ~|pend_nx & ~s1_nx & ~s2_nx;
      s1_v         <= s1_nx;
      mem_write_en <= s2_nx;
      if (gnt_v) ptr <= g == PW'(NUM_ALLOC - 1) ? '0 : g + 1'b1;
      if (s2_load && s1_v) begin
        mem_addr <= s1_addr;
        mem_data <= act;
      end
      for (int i = 0; i < NUM_ALLOC; i++) if (alloc_assign[i]) slot_addr[i] <= assign_addr;
    end
  end
  // Captured result takes the address latched before any same-cycle assign.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ALLOC; i++)
      if (cap[i]) begin
        res[i]      <= alloc_result[18*i +: 18];
        res_addr[i] <= slot_addr[i];
      end
    if (s1_adv && gnt_v) begin
      s1_sum  <= sat;
      s1_addr <= res_addr[g];
    end
  end
endmodule

// File: tb/tb_allocator_writeback.sv
// tb_allocator_writeback: random and directed stimulus against a slot/queue reference model with a decoupled write scoreboard.
module tb_allocator_writeback;
  localparam int N = 4, AW = 16, LS = 3;
  logic              clk = 0, rst, mem_ready;
  logic [N-1:0]      alloc_assign, alloc_done, alloc_ack;
  logic [AW-1:0]     assign_addr, mem_addr;
  logic [18*N-1:0]   alloc_result;
  logic [17:0]       filter_bias, mem_data;
  logic              mem_write_en, idle, overflow;
  int                vectors = 0, miscompares = 0;
  longint            cyc = 0;
  bit                m_pend [N];
  int                m_res [N];
  logic [AW-1:0]     m_slot [N], m_raddr [N];
  int                m_ptr = 0;
  bit                m_ovf = 0;
  longint            infl[$];
  logic [AW+17:0]    exp_q[$];
  logic              hold_v = 0;
  logic [AW+17:0]    hold_w;
  allocator_writeback #(.NUM_ALLOC(N), .ADDR_W(AW), .LEAK_SHIFT(LS)) dut (
    .clk(clk), .rst(rst), .alloc_assign(alloc_assign), .assign_addr(assign_addr),
    .alloc_done(alloc_done), .alloc_result(alloc_result), .filter_bias(filter_bias),
    .alloc_ack(alloc_ack), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .idle(idle), .overflow(overflow));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [17:0] ref_act(int r, int b);
    int s = r + b;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
`ifdef WRITEBACK_LEAKY_RELU_EN
    if (s < 0) s = (s - ((1 << LS) - 1)) / (1 << LS);
`endif
    return 18'(s);
  endfunction
  function automatic bit m_empty();
    foreach (m_pend[i]) if (m_pend[i]) return 0;
    return infl.size() == 0;
  endfunction
  // One clock of the reference model; inputs are already driven.
  task automatic step();
    int g = -1;
    logic [N-1:0] ack_e = '0;
    bit wen_e, idle_e;
    wen_e  = infl.size() > 0 && infl[0] <= cyc - 2;
    idle_e = m_empty();
    if (rst && (infl.size() < 2 || mem_ready))
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (m_pend[i]) begin g = i; break; end
      end
    if (g >= 0) begin
      ack_e[g] = 1'b1;
      exp_q.push_back({m_raddr[g], ref_act(m_res[g], int'($signed(filter_bias)))});
      infl.push_back(cyc);
    end
    @(negedge clk);
    chk("alloc_ack", alloc_ack, ack_e);
    chk("mem_write_en", mem_write_en, wen_e);
    chk("idle", idle, idle_e);
    chk("overflow", overflow, m_ovf);
    @(posedge clk);
    if (!rst) begin
      foreach (m_pend[i]) begin m_pend[i] = 0; m_slot[i] = '0; end
      m_ptr = 0; m_ovf = 0;
      infl.delete(); exp_q.delete();
    end else begin
      if (wen_e && mem_ready) void'(infl.pop_front());
      for (int i = 0; i < N; i++) begin
        if (alloc_done[i] && m_pend[i] && g != i) m_ovf = 1;
        if (alloc_done[i] && (!m_pend[i] || g == i)) begin
          m_pend[i]  = 1;
          m_res[i]   = int'($signed(alloc_result[18*i +: 18]));
          m_raddr[i] = m_slot[i];
        end else if (g == i) m_pend[i] = 0;
        if (alloc_assign[i]) m_slot[i] = assign_addr;
      end
      if (g >= 0) m_ptr = (g + 1) % N;
    end
    cyc++;
    #1;
  endtask
  task automatic drive(logic [N-1:0] d, logic [N-1:0] a, logic [AW-1:0] ad);
    alloc_done = d; alloc_assign = a; assign_addr = ad;
    step();
    alloc_done = '0; alloc_assign = '0;
  endtask
  task automatic set_res(int i, logic [17:0] v);
    alloc_result[18*i +: 18] = v;
  endtask
  task automatic drain();
    int k = 0;
    while (!m_empty() && k < 60) begin step(); k++; end
    if (!m_empty()) chk("drain_timeout", 1, 0);
    step();
  endtask
  // Write-side scoreboard and hold-stability monitor.
  initial forever begin
    @(negedge clk);
    if (hold_v) chk("hold_stable", {mem_write_en, mem_addr, mem_data}, {1'b1, hold_w});
    if (rst && mem_write_en && mem_ready) begin
      if (exp_q.size() == 0) chk("unexpected_write", {mem_addr, mem_data}, 0);
      else chk("mem_word", {mem_addr, mem_data}, exp_q.pop_front());
    end
    hold_v = rst && mem_write_en && !mem_ready;
    hold_w = {mem_addr, mem_data};
  end
  initial begin
    rst = 0; mem_ready = 0; alloc_assign = '0; alloc_done = '0; assign_addr = '0;
    alloc_result = '0; filter_bias = '0;
    foreach (m_pend[i]) begin m_pend[i] = 0; m_slot[i] = '0; m_res[i] = 0; m_raddr[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ack", alloc_ack, 0);
    chk("rst_wen", mem_write_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst = 1; mem_ready = 1;
    drive('0, 4'b0001, 16'h0010);
    filter_bias = -18'sd50; set_res(0, 18'd200);
    drive(4'b0001, '0, '0);
    drain();
    drive('0, 4'b0010, 16'h0123);
    filter_bias = 18'sd4; set_res(1, 18'h3FF9C);
    drive(4'b0010, '0, '0);
    drain();
    filter_bias = 18'sd10; set_res(2, 18'h1FFFF);
    drive(4'b0100, 4'b0100, 16'hBEEF);
    drain();
    filter_bias = -18'sd1; set_res(3, 18'h20000);
    drive(4'b1000, '0, '0);
    drain();
    set_res(1, 18'd7);
    drive(4'b0010, '0, '0);
    drain();
    for (int i = 0; i < N; i++) set_res(i, 18'(1000 * (i + 1)));
    drive(4'b1111, 4'b1111, 16'h0400);
    drain();
    mem_ready = 0;
    drive(4'b0111, '0, '0);
    repeat (5) step();
    mem_ready = 1;
    drain();
    mem_ready = 0;
    set_res(1, 18'd5); set_res(2, 18'd6);
    drive(4'b0110, '0, '0);
    repeat (2) step();
    set_res(0, 18'd111);
    drive(4'b0001, '0, '0);
    set_res(0, 18'd222);
    drive(4'b0001, '0, '0);
    step();
    mem_ready = 1;
    step();
    rst = 0; mem_ready = 0;
    step();
    rst = 1; mem_ready = 1;
    repeat (4) step();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 250) != 0;
      mem_ready = rst && ($urandom % 10) < 7;
      alloc_done = '0; alloc_assign = '0;
      for (int i = 0; i < N; i++) begin
        alloc_done[i] = ($urandom % 3) == 0;
        alloc_assign[i] = ($urandom % 8) == 0;
        case ($urandom % 6)
          0: set_res(i, 18'h1FFFF);
          1: set_res(i, 18'h20000);
          default: set_res(i, 18'($urandom));
        endcase
      end
      assign_addr = 16'($urandom);
      if (m_empty() && alloc_done == '0)
        filter_bias = ($urandom % 2) ? 18'($urandom) : (($urandom % 2) ? 18'h1FFFF : 18'h20000);
      step();
    end
    alloc_done = '0; alloc_assign = '0; rst = 1; mem_ready = 1;
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
